lut_eval_seq: RTL and testbench
===============================

Name: lut_eval_seq

Overview:
- Parametrised, registered successor to the team's fixed 5-input combinational logic circuit.
- Evaluates a programmable N_IN-input Boolean function, held as a 2^N_IN-entry truth table, on a stream of input vectors.
- Stream uses a valid/ready handshake; output is registered.
- A saturating counter tracks accepted outputs that evaluate to 1.
- Sits between a stimulus source and a downstream consumer.
- Function is reprogrammed at run time through a single-bit write port.

Parameters:
- N_IN, 5, number of function inputs (1..10); truth table holds 2^N_IN bits.
- CNT_W, 8, width of MATCH_CNT.
- INIT_TABLE, 0, reset value of the truth table, 2^N_IN bits; bit k = function value for input vector k.

Ports:
- CLK  in  1  rising-edge clock.
- RST_N  in  1  asynchronous active-low reset.
- CFG_WR  in  1  truth-table write strobe.
- CFG_ADDR  in  N_IN  truth-table entry to write.
- CFG_DATA  in  1  value written to entry CFG_ADDR.
- IN_VALID  in  1  X is valid.
- IN_READY  out  1  block can accept X this cycle.
- X  in  N_IN  input vector; X[N_IN-1] maps to the old A, X[0] to the old E for N_IN=5.
- Y_VALID  out  1  Y holds an unconsumed result.
- Y_READY  in  1  consumer accepts Y this cycle.
- Y  out  1  function value of the last accepted X.
- CNT_CLR  in  1  synchronous clear of MATCH_CNT.
- MATCH_CNT  out  CNT_W  count of consumed results with Y=1.

Behaviour:
- Reset (RST_N=0, asynchronous, immediate):
  - Y_VALID=0, Y=0, MATCH_CNT=0.
  - Truth table = INIT_TABLE.
  - IN_READY=1 as soon as reset deasserts.
- Handshake rules:
  - IN_READY = !Y_VALID || Y_READY (combinational; single output stage).
  - Input transfer: IN_VALID && IN_READY at a rising edge.
  - Output transfer: Y_VALID && Y_READY at a rising edge.
- Output stage, two states:
  - EMPTY (Y_VALID=0), FULL (Y_VALID=1).
  - EMPTY + input transfer -> FULL; Y <= table[X].
  - FULL + output transfer, no input transfer -> EMPTY; Y holds its last value.
  - FULL + output and input transfer in the same cycle -> FULL; Y <= table[new X]. Full throughput is one result per cycle.
  - FULL + Y_READY=0: Y and Y_VALID hold; IN_READY=0; X is ignored.
- Latency: exactly 1 cycle from input transfer to Y_VALID/Y.
- IN_VALID may drop without a transfer. X is not required to stay stable while IN_READY=0.
- Configuration:
  - CFG_WR=1 writes CFG_DATA to table[CFG_ADDR] at the edge.
  - Writes are accepted in any state and never stall.
  - Write and input transfer to the same entry in the same cycle: evaluation uses the OLD entry value; the new value applies from the next transfer.
  - A registered Y is never altered by a later write.
- Counter:
  - On each output transfer with Y=1, MATCH_CNT increments by 1.
  - Saturates at 2^CNT_W-1; no wrap.
  - CNT_CLR=1 sets it to 0 and has priority over a simultaneous increment.
- Reset mid-operation: a pending Y is discarded. The table returns to INIT_TABLE, so any programmed entries are lost.
- X containing X/Z in simulation: no requirement. The bench drives only known values.

Optional Feature:
- Macro LUT_EVAL_EDGE_EN, which adds output port Y_RISE (1 bit, reset 0).
- With the macro defined:
  - Y_RISE pulses high for one cycle, in the cycle after an output transfer with Y=1 whose preceding output transfer had Y=0.
  - Consumed-history register resets to 0, so the first consumed 1 after reset pulses.
  - CNT_CLR does not affect Y_RISE or the history register.
- Without the macro: port and logic are absent. Remaining behaviour is identical.

Test Plan:
1. Reset value (N_IN=5, INIT_TABLE=32'hA5A5F00F), Y_READY=1:
   - X=0 -> Y=1 one cycle later.
   - X=4 -> Y=0.
   - X=31 -> Y=1.
   - MATCH_CNT=2 after all three are consumed.
2. Programming: write CFG_ADDR=4, CFG_DATA=1, then X=4 -> Y=1. Write-and-evaluate the same entry in the same cycle, clearing entry 0 with X=0 -> Y=1 (old value); X=0 again next transfer -> Y=0.
3. Backpressure: Y_READY=0 with IN_VALID=1 and X stepping 0..3:
   - After the first transfer, IN_READY=0.
   - Y stays at table[0] for 5 cycles.
   - On Y_READY=1, stream resumes at one result per cycle with no lost or duplicated results.
4. Saturation (CNT_W=3): consume 10 results with Y=1 -> MATCH_CNT=7. Then CNT_CLR and an increment in the same cycle -> MATCH_CNT=0.
5. Async reset: assert RST_N=0 mid-stream while Y_VALID=1 and between clock edges:
   - Y_VALID=0 and MATCH_CNT=0 immediately.
   - Table reverts to INIT_TABLE, checked by X=4 -> Y=0.
6. LUT_EVAL_EDGE_EN: consumed Y sequence 0,1,1,0,1 -> Y_RISE pulses after the 2nd and 5th consumptions only.

Source files
------------

// File: rtl/lut_eval_seq_if.sv
// Stream interface for lut_eval_seq: valid/ready input vectors and the registered result.
// master = source/consumer side (bench), slave = the evaluator.
interface lut_eval_seq_if #(
    parameter int N_IN = 5
);
    logic            in_valid;
    logic            in_ready;
    logic [N_IN-1:0] x;
    logic            y_valid;
    logic            y_ready;
    logic            y;

    modport master (
        output in_valid,
        output x,
        output y_ready,
        input  in_ready,
        input  y_valid,
        input  y
    );

    modport slave (
        input  in_valid,
        input  x,
        input  y_ready,
        output in_ready,
        output y_valid,
        output y
    );
endinterface

// File: rtl/lut_eval_seq.sv
// Registered N_IN-input truth-table evaluator with a single output stage and a saturating match counter.
// Optional macro LUT_EVAL_EDGE_EN adds y_rise, a pulse on each consumed 0->1 transition of y.
module lut_eval_seq #(
    parameter int                     N_IN       = 5,
    parameter int                     CNT_W      = 8,
    parameter logic [(1<<N_IN)-1:0]   INIT_TABLE = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    lut_eval_seq_if.slave     bus,
    input  logic              cfg_wr,
    input  logic [N_IN-1:0]   cfg_addr,
    input  logic              cfg_data,
    input  logic              cnt_clr,
`ifdef LUT_EVAL_EDGE_EN
    output logic              y_rise,
`endif
    output logic [CNT_W-1:0]  match_cnt
);

    localparam int              TBL_W   = 1 << N_IN;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic {EMPTY, FULL} state_t;

    state_t             state;
    state_t             state_next;
    logic [TBL_W-1:0]   lut;
    logic               y_q;
    logic               in_fire;
    logic               out_fire;

    assign in_fire  = bus.in_valid && bus.in_ready;
    assign out_fire = bus.y_valid && bus.y_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            EMPTY:   if (in_fire) state_next = FULL;
            FULL:    if (out_fire && !in_fire) state_next = EMPTY;
            default: state_next = EMPTY;
        endcase
    end

    // Single output stage: a new vector is accepted whenever the slot is empty or being drained.
    always_comb begin
        bus.y_valid  = (state == FULL);
        bus.in_ready = (state == EMPTY) || bus.y_ready;
        bus.y        = y_q;
    end

    // The lookup reads the pre-write table, so a same-cycle write to the same entry is seen one transfer later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q <= 1'b0;
        end else if (in_fire) begin
            y_q <= lut[bus.x];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lut <= INIT_TABLE;
        end else if (cfg_wr) begin
            lut[cfg_addr] <= cfg_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            match_cnt <= '0;
        end else if (cnt_clr) begin
            match_cnt <= '0;
        end else if (out_fire && y_q && (match_cnt != CNT_MAX)) begin
            match_cnt <= match_cnt + 1'b1;
        end
    end

`ifdef LUT_EVAL_EDGE_EN
    logic last_consumed;

    // History only advances on consumption, so held or unconsumed results never create an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_consumed <= 1'b0;
            y_rise        <= 1'b0;
        end else if (out_fire) begin
            last_consumed <= y_q;
            y_rise        <= y_q && !last_consumed;
        end else begin
            y_rise        <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_lut_eval_seq.sv
// Scoreboard bench for lut_eval_seq: driver pushes expected results from a behavioural model,
// an independent negedge monitor checks every presented result, the handshake and the counter.
module tb_lut_eval_seq;

    localparam int          N_IN    = 5;
    localparam int          CNT_W   = 3;
    localparam logic [31:0] INIT    = 32'hA5A5F00F;
    localparam int          CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             cfg_wr = 1'b0;
    logic [N_IN-1:0]  cfg_addr = '0;
    logic             cfg_data = 1'b0;
    logic             cnt_clr = 1'b0;
    logic [CNT_W-1:0] match_cnt;
`ifdef LUT_EVAL_EDGE_EN
    logic             y_rise;
`endif

    lut_eval_seq_if #(.N_IN(N_IN)) bus ();

    lut_eval_seq #(
        .N_IN       (N_IN),
        .CNT_W      (CNT_W),
        .INIT_TABLE (INIT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .cfg_wr     (cfg_wr),
        .cfg_addr   (cfg_addr),
        .cfg_data   (cfg_data),
        .cnt_clr    (cnt_clr),
`ifdef LUT_EVAL_EDGE_EN
        .y_rise     (y_rise),
`endif
        .match_cnt  (match_cnt)
    );

    always #5 clk = ~clk;

    // Behavioural model: function table, one-slot output buffer and consumed-result statistics.
    logic [31:0] m_lut  = INIT;
    bit          m_full = 1'b0;
    bit          m_y    = 1'b0;
    int          m_cnt  = 0;
    bit          m_hist = 1'b0;
    bit          m_rise = 1'b0;
    bit          sb[$];

    int vectors  = 0;
    int failures = 0;
    bit done     = 1'b0;

    task automatic checkOutput(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drives one cycle of stimulus starting just after a rising edge and advances the model at the next edge.
    task automatic applyStimulus(input bit iv, input logic [N_IN-1:0] xv, input bit yr,
                                 input bit wr, input logic [N_IN-1:0] addr, input bit data,
                                 input bit clr);
        bit in_fire;
        bit out_fire;
        bus.in_valid = iv;
        bus.x        = xv;
        bus.y_ready  = yr;
        cfg_wr       = wr;
        cfg_addr     = addr;
        cfg_data     = data;
        cnt_clr      = clr;
        @(posedge clk);
        in_fire  = iv && (!m_full || yr);
        out_fire = m_full && yr;
        if (clr)
            m_cnt = 0;
        else if (out_fire && m_y && m_cnt < CNT_MAX)
            m_cnt++;
        if (out_fire) begin
            m_rise = m_y && !m_hist;
            m_hist = m_y;
        end else begin
            m_rise = 1'b0;
        end
        if (in_fire) begin
            m_y    = m_lut[xv];
            m_full = 1'b1;
            sb.push_back(m_lut[xv]);
        end else if (out_fire) begin
            m_full = 1'b0;
        end
        if (wr)
            m_lut[addr] = data;
        #1;
    endtask

    task automatic idleCycles(input int n, input bit yr);
        for (int i = 0; i < n; i++)
            applyStimulus(1'b0, '0, yr, 1'b0, '0, 1'b0, 1'b0);
    endtask

    // Asserts reset between edges while a result is pending and checks the immediate clear.
    task automatic doReset();
        bus.in_valid = 1'b0;
        cfg_wr       = 1'b0;
        cnt_clr      = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        checkOutput("rst_y_valid", int'(bus.y_valid), 0);
        checkOutput("rst_y", int'(bus.y), 0);
        checkOutput("rst_cnt", int'(match_cnt), 0);
        m_lut  = INIT;
        m_full = 1'b0;
        m_y    = 1'b0;
        m_cnt  = 0;
        m_hist = 1'b0;
        m_rise = 1'b0;
        sb.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        checkOutput("rst_in_ready", int'(bus.in_ready), 1);
    endtask

    // Monitor: compares whatever the DUT presents against the scoreboard and model, independent of the driver.
    always @(negedge clk) begin
        if (!done) begin
            checkOutput("y_valid", int'(bus.y_valid), int'(m_full));
            checkOutput("in_ready", int'(bus.in_ready), int'(!m_full || bus.y_ready));
            checkOutput("match_cnt", int'(match_cnt), m_cnt);
`ifdef LUT_EVAL_EDGE_EN
            checkOutput("y_rise", int'(y_rise), int'(m_rise));
`endif
            if (bus.y_valid) begin
                if (sb.size() == 0) begin
                    checkOutput("sb_underflow", 1, 0);
                end else begin
                    checkOutput("y", int'(bus.y), int'(sb[0]));
                    if (bus.y_ready)
                        void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        bus.in_valid = 1'b0;
        bus.x        = '0;
        bus.y_ready  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_y_valid", int'(bus.y_valid), 0);
        checkOutput("reset_cnt", int'(match_cnt), 0);
        rst_n = 1'b1;

        // Reset table contents: 0 -> 1, 4 -> 0, 31 -> 1.
        applyStimulus(1'b1, 5'd0,  1'b1, 1'b0, '0, 1'b0, 1'b0);
        applyStimulus(1'b1, 5'd4,  1'b1, 1'b0, '0, 1'b0, 1'b0);
        applyStimulus(1'b1, 5'd31, 1'b1, 1'b0, '0, 1'b0, 1'b0);
        idleCycles(1, 1'b1);
        checkOutput("t1_cnt", int'(match_cnt), 2);

        // Programming, including write and evaluate of the same entry in one cycle.
        applyStimulus(1'b0, 5'd0, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0);
        applyStimulus(1'b1, 5'd4, 1'b1, 1'b0, '0, 1'b0, 1'b0);
        applyStimulus(1'b1, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
        applyStimulus(1'b1, 5'd0, 1'b1, 1'b0, '0, 1'b0, 1'b0);
        idleCycles(1, 1'b1);

        // Backpressure: hold the first result for several cycles, then resume at full rate.
        for (int i = 0; i < 6; i++)
            applyStimulus(1'b1, 5'(i % 4), 1'b0, 1'b0, '0, 1'b0, 1'b0);
        for (int i = 1; i < 4; i++)
            applyStimulus(1'b1, 5'(i), 1'b1, 1'b0, '0, 1'b0, 1'b0);
        idleCycles(1, 1'b1);

        // Saturation: ten consumed ones on a 3-bit counter, then clear against a same-cycle increment.
        applyStimulus(1'b0, 5'd0, 1'b1, 1'b1, 5'd7, 1'b1, 1'b1);
        for (int i = 0; i < 10; i++)
            applyStimulus(1'b1, 5'd7, 1'b1, 1'b0, '0, 1'b0, 1'b0);
        idleCycles(1, 1'b1);
        checkOutput("sat_cnt", int'(match_cnt), 7);
        applyStimulus(1'b1, 5'd7, 1'b1, 1'b0, '0, 1'b0, 1'b0);
        applyStimulus(1'b0, 5'd0, 1'b1, 1'b0, '0, 1'b0, 1'b1);
        checkOutput("clr_prio_cnt", int'(match_cnt), 0);

        // Mid-stream asynchronous reset, then confirm the table reverted (entry 4 back to 0).
        applyStimulus(1'b1, 5'd4, 1'b0, 1'b1, 5'd4, 1'b1, 1'b0);
        applyStimulus(1'b1, 5'd4, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        doReset();
        applyStimulus(1'b1, 5'd4, 1'b1, 1'b0, '0, 1'b0, 1'b0);
        idleCycles(1, 1'b1);

        // Consumed sequence 0,1,1,0,1 for the rising-edge pulse.
        applyStimulus(1'b1, 5'd4, 1'b1, 1'b0, '0, 1'b0, 1'b0);
        applyStimulus(1'b1, 5'd0, 1'b1, 1'b0, '0, 1'b0, 1'b0);
        applyStimulus(1'b1, 5'd0, 1'b1, 1'b0, '0, 1'b0, 1'b0);
        applyStimulus(1'b1, 5'd4, 1'b1, 1'b0, '0, 1'b0, 1'b0);
        applyStimulus(1'b1, 5'd0, 1'b1, 1'b0, '0, 1'b0, 1'b0);
        idleCycles(2, 1'b1);

        // Randomised traffic with interleaved reprogramming and clears.
        for (int i = 0; i < 400; i++)
            applyStimulus($urandom_range(0, 3) != 0, 5'($urandom), $urandom_range(0, 3) != 0,
                          $urandom_range(0, 7) == 0, 5'($urandom), 1'($urandom),
                          $urandom_range(0, 31) == 0);

        idleCycles(3, 1'b1);
        checkOutput("sb_drained", sb.size(), 0);
        done = 1'b1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, failures);
        $finish;
    end

endmodule
